// File: rtl/vit_tbck_ctrl.sv
// Traceback controller for the K=3, 4-state Viterbi decoder.
// Buffers one frame of ACS survivor decisions, selects a traceback start
// state, walks the survivor memory backwards one step per cycle and hands
// the decoded frame to the sink over a valid/ready handshake.
//
// Optional build macro TBCK_ZERO_TERM_EN: frames are zero-terminated, so
// the traceback always starts in state 2'b00. The path-metric inputs are
// ignored and no comparator is built.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. acs_ready is high only in FILL. Once
// out_valid rises, it and data_out hold until the transfer.
module vit_tbck_ctrl #(
  parameter int FRAME_LEN = 8,
  parameter int PM_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acs_valid,
  output logic                 acs_ready,
  input  logic [3:0]           acs_dec,
  input  logic [PM_W-1:0]      pm_00,
  input  logic [PM_W-1:0]      pm_01,
  input  logic [PM_W-1:0]      pm_10,
  input  logic [PM_W-1:0]      pm_11,
  output logic [FRAME_LEN-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [7:0]           frame_cnt,
  output logic [1:0]           tb_start
);

  localparam int PTR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_TRACE = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]           state;
  logic [PTR_W-1:0]     wr_cnt;
  logic [PTR_W-1:0]     rd_ptr;
  logic [3:0]           mem [FRAME_LEN];
  logic [1:0]           tb_state;
  logic [FRAME_LEN-1:0] tb_shift;
  logic [FRAME_LEN-1:0] shift_next;
  logic [1:0]           start_sel;
  logic                 accept;
  logic                 last_accept;

  assign acs_ready   = (state == ST_FILL);
  assign busy        = (state == ST_TRACE) || (state == ST_OUT);
  assign accept      = acs_valid && acs_ready;
  assign last_accept = accept && (wr_cnt == LAST_IDX);

`ifdef TBCK_ZERO_TERM_EN
  // Zero-terminated frames always end in state 00; metrics are not needed.
  logic pm_unused;
  assign pm_unused = ^{pm_00, pm_01, pm_10, pm_11};
  assign start_sel = 2'b00;
`else
  logic [PM_W-1:0] best_pm;

  // Unsigned argmin of the final path metrics; strict '<' keeps the lowest index on ties.
  always_comb begin
    start_sel = 2'b00;
    best_pm   = pm_00;
    if (pm_01 < best_pm) begin
      start_sel = 2'b01;
      best_pm   = pm_01;
    end
    if (pm_10 < best_pm) begin
      start_sel = 2'b10;
      best_pm   = pm_10;
    end
    if (pm_11 < best_pm) begin
      start_sel = 2'b11;
      best_pm   = pm_11;
    end
  end
`endif

  // Decoded word with this cycle's traceback bit already merged in.
  always_comb begin
    shift_next         = tb_shift;
    shift_next[rd_ptr] = tb_state[1];
  end

  // Survivor memory: one 4-bit decision vector per trellis step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        mem[i] <= 4'b0000;
      end
    end else if (accept) begin
      mem[wr_cnt] <= acs_dec;
    end
  end

  // Frame sequencing: FILL -> TRACE (FRAME_LEN cycles) -> OUT -> FILL.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_FILL;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      tb_state  <= 2'b00;
      tb_shift  <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_cnt <= 8'd0;
      tb_start  <= 2'b00;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (last_accept) begin
              tb_start <= start_sel;
              tb_state <= start_sel;
              wr_cnt   <= '0;
              rd_ptr   <= LAST_IDX;
              state    <= ST_TRACE;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        ST_TRACE: begin
          // Emit the newest bit of the current state, then step to its predecessor.
          tb_shift <= shift_next;
          tb_state <= {tb_state[0], mem[rd_ptr][tb_state]};
          if (rd_ptr == '0) begin
            data_out  <= shift_next;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            rd_ptr <= rd_ptr - 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= ST_FILL;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vit_tbck_ctrl.sv
// Bench for vit_tbck_ctrl: directed frames from the test plan plus random
// frames with idle gaps and output backpressure, checked against a
// behavioural traceback model computed from the trellis rules.
module tb_vit_tbck_ctrl;

  localparam int FL  = 8;
  localparam int PMW = 8;

  logic           clk;
  logic           rst;
  logic           acs_valid;
  logic           acs_ready;
  logic [3:0]     acs_dec;
  logic [PMW-1:0] pm_00, pm_01, pm_10, pm_11;
  logic [FL-1:0]  data_out;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic [7:0]     frame_cnt;
  logic [1:0]     tb_start;

  int vectors;
  int miscompares;

  // Current frame stimulus and model results.
  logic [3:0]     f_dec [FL];
  logic [PMW-1:0] f_pm  [4];
  logic [1:0]     exp_start;
  logic [FL-1:0]  exp_word;
  logic [7:0]     exp_frames;

  vit_tbck_ctrl #(.FRAME_LEN(FL), .PM_W(PMW)) dut (
    .clk       (clk),
    .rst       (rst),
    .acs_valid (acs_valid),
    .acs_ready (acs_ready),
    .acs_dec   (acs_dec),
    .pm_00     (pm_00),
    .pm_01     (pm_01),
    .pm_10     (pm_10),
    .pm_11     (pm_11),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .tb_start  (tb_start)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: choose start state, then walk predecessors newest to oldest.
  task automatic model();
    logic [1:0] cur;
    logic [3:0] d;
`ifdef TBCK_ZERO_TERM_EN
    exp_start = 2'b00;
`else
    exp_start = 2'b00;
    for (int s = 1; s < 4; s++) begin
      if (f_pm[s] < f_pm[exp_start]) exp_start = 2'(s);
    end
`endif
    cur = exp_start;
    exp_word = '0;
    for (int i = FL - 1; i >= 0; i--) begin
      exp_word[i] = cur[1];
      d = f_dec[i];
      cur = {cur[0], d[cur]};
    end
  endtask

  task automatic set_const(input logic [3:0] d, input logic [PMW-1:0] p0, p1, p2, p3);
    for (int i = 0; i < FL; i++) f_dec[i] = d;
    f_pm[0] = p0; f_pm[1] = p1; f_pm[2] = p2; f_pm[3] = p3;
  endtask

  task automatic set_rand();
    for (int i = 0; i < FL; i++) f_dec[i] = 4'($urandom_range(0, 15));
    for (int s = 0; s < 4; s++) f_pm[s] = PMW'($urandom_range(0, 15));
  endtask

  task automatic drive_noise();
    acs_dec = 4'($urandom_range(0, 15));
    pm_00 = PMW'($urandom); pm_01 = PMW'($urandom);
    pm_10 = PMW'($urandom); pm_11 = PMW'($urandom);
  endtask

  // Driver: feed FL accepted steps with random idle gaps; stops at the negedge after the last accept.
  task automatic fill_frame();
    model();
    for (int i = 0; i < FL; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        acs_valid = 1'b0;
        drive_noise();
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("fill_ready", 32'(acs_ready), 32'd1);
      end
      acs_valid = 1'b1;
      drive_noise();
      acs_dec = f_dec[i];
      if (i == FL - 1) begin
        pm_00 = f_pm[0]; pm_01 = f_pm[1]; pm_10 = f_pm[2]; pm_11 = f_pm[3];
      end
      @(negedge clk);
    end
    acs_valid = 1'b0;
    out_ready = 1'b0;
    drive_noise();
    check("trace_ready", 32'(acs_ready), 32'd0);
    check("trace_busy", 32'(busy), 32'd1);
    check("tb_start", 32'(tb_start), 32'(exp_start));
  endtask

  // Wait for the decoded word, hold it under backpressure, then take it.
  task automatic finish_frame(input int bp);
    int cycles;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 4 * FL) begin
      @(negedge clk);
      cycles++;
    end
    check("out_latency", 32'(cycles), 32'(FL));
    check("data_out", 32'(data_out), 32'(exp_word));
    check("out_busy", 32'(busy), 32'd1);
    check("out_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(data_out), 32'(exp_word));
      check("bp_ready", 32'(acs_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_frames = exp_frames + 8'd1;
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_ready", 32'(acs_ready), 32'd1);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("hs_tb_start_hold", 32'(tb_start), 32'(exp_start));
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_tb_start", 32'(tb_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acs_ready", 32'(acs_ready), 32'd1);
  endtask

  // Directed sequence followed by random frames.
  initial begin
    vectors = 0;
    miscompares = 0;
    exp_frames = 8'd0;
    rst = 1'b0;
    acs_valid = 1'b0;
    out_ready = 1'b0;
    acs_dec = 4'd0;
    pm_00 = '0; pm_01 = '0; pm_10 = '0; pm_11 = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b1;

    // All-zero decisions, state 00 best.
    set_const(4'b0000, 8'd0, 8'd5, 8'd5, 8'd5);
    fill_frame();
    finish_frame(0);

    // All-one decisions, state 11 best.
    set_const(4'b1111, 8'd9, 8'd9, 8'd9, 8'd1);
    fill_frame();
    finish_frame(0);

    // State 10 best over zero decisions.
    set_const(4'b0000, 8'd5, 8'd5, 8'd2, 8'd5);
    fill_frame();
    finish_frame(1);

    // All metrics tied.
    set_const(4'b0000, 8'd7, 8'd7, 8'd7, 8'd7);
    fill_frame();
    finish_frame(0);

    // Five cycles of output backpressure.
    set_rand();
    fill_frame();
    finish_frame(5);

    // Reset pulse in the fourth traceback cycle.
    set_rand();
    fill_frame();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_frames = 8'd0;
    check_reset_state();
    repeat (6) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    set_const(4'b1111, 8'd9, 8'd9, 8'd9, 8'd1);
    fill_frame();
    finish_frame(0);

    // Zero-terminated check: state 11 has the lowest metric.
    set_const(4'b0000, 8'd6, 8'd6, 8'd6, 8'd0);
    fill_frame();
    finish_frame(0);

    // Random frames.
    for (int f = 0; f < 30; f++) begin
      set_rand();
      fill_frame();
      finish_frame($urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vit_tbck_ctrl.md
Name: vit_tbck_ctrl

Overview:
Traceback controller for the K=3, 4-state Viterbi decoder. It buffers per-step ACS survivor decisions for one frame and picks the traceback start state from the final path metrics. It then walks the survivor memory backwards one step per cycle and delivers the decoded frame as a parallel word over a valid/ready handshake. It sits between the ACS/path-metric unit and the byte sink, and sequences traceback instead of free-running.

Parameters:
FRAME_LEN, 8, trellis steps per frame; also the decoded output word width (min 2).
PM_W, 8, path-metric width in bits (unsigned).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-low reset.
acs_valid  input  1  ACS step result valid.
acs_ready  output  1  controller accepts an ACS step.
acs_dec  input  4  survivor decision bit per state; bit s = LSB of the chosen predecessor of state s.
pm_00, pm_01, pm_10, pm_11  input  PM_W  path metrics after the step presented this cycle.
data_out  output  FRAME_LEN  decoded frame; bit i = input bit of trellis step i (step 0 = first accepted).
out_valid  output  1  data_out valid.
out_ready  input  1  sink accepts data_out.
busy  output  1  high in TRACE or OUT.
frame_cnt  output  8  frames delivered, wraps 255->0.
tb_start  output  2  start state chosen for the current/last traceback.

Behaviour:
- Trellis definition: state s = {s[1], s[0]}, where s[1] is the newest input bit.
- Decoded bit at state s = s[1].
- Predecessor of s = {s[0], acs_dec_stored[step][s]}.
- States: FILL, TRACE, OUT (2-bit encoding, no other states reachable).
- Reset (rst=0 at a clock edge, from any state, including mid-TRACE/OUT):
  - state=FILL, wr_cnt=0, rd_ptr=0.
  - data_out=0, out_valid=0, busy=0, frame_cnt=0, tb_start=2'b00.
  - Survivor memory cleared to 0.
- FILL:
  - acs_ready=1.
  - On acs_valid&acs_ready: mem[wr_cnt]<=acs_dec, and wr_cnt increments.
  - If wr_cnt==FRAME_LEN-1 on that accept:
    - Latch tb_start = argmin(pm_00..pm_11), unsigned compare; ties resolve to the lowest state index.
    - wr_cnt<=0, rd_ptr<=FRAME_LEN-1, go TRACE.
  - acs_valid=0 in FILL: hold, no change.
- TRACE:
  - acs_ready=0, busy=1.
  - Each cycle (cur = tb_state, initialised from tb_start):
    - tb_shift[rd_ptr]<=cur[1].
    - tb_state<={cur[0], mem[rd_ptr][cur]}.
  - Exactly FRAME_LEN cycles.
  - In the rd_ptr==0 cycle:
    - data_out<=assembled word including the bit written this cycle.
    - out_valid<=1, go OUT.
  - rd_ptr never wraps; the decrement below 0 is not performed.
- OUT:
  - acs_ready=0, busy=1, out_valid=1.
  - data_out stable until handshake.
  - On out_valid&out_ready: out_valid<=0, frame_cnt<=frame_cnt+1, go FILL.
  - out_ready high while not in OUT is ignored.
- Latency:
  - Last accept at edge T -> out_valid high after edge T+FRAME_LEN.
  - Handshake at edge H -> acs_ready high after H.
  - Throughput: one frame per FRAME_LEN accepts + FRAME_LEN + ≥1 cycles; no overlap of fill and trace.
- tb_start holds its value until the next frame's start selection.
- Pointer widths: $clog2(FRAME_LEN).
- acs_dec/pm sampled only on an accepting edge.

Optional Feature:
TBCK_ZERO_TERM_EN
- Defined: frames are zero-terminated. tb_start is forced to 2'b00 and pm_* inputs are ignored; the comparator is not built.
- Undefined: min-metric start-state selection as above.

Test Plan:
- Reset, then 8 steps with acs_dec=4'b0000 and pm_00=0, others=5 -> tb_start=00, after 8 TRACE cycles out_valid=1, data_out=8'h00.
- 8 steps with acs_dec=4'b1111, pm_11=1, others=9 -> tb_start=11, data_out=8'hFF, frame_cnt 0->1 on handshake.
- acs_dec=4'b0000 for all steps, pm_10=2 minimum -> tb_start=10, data_out=8'h80. With all pm equal=7 -> tb_start=00 (tie rule).
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid stays 1, data_out constant, acs_ready=0. out_ready=1 -> acs_ready=1 the next cycle.
- rst=0 for one cycle during TRACE cycle 4 -> next cycle FILL, out_valid=0, data_out=0, frame_cnt=0. A following full frame decodes correctly.
- TBCK_ZERO_TERM_EN defined, pm_11=0 minimum, acs_dec=4'b0000 -> tb_start=00, data_out=8'h00.
